uart_tx_byte: RTL and testbench



---
 rtl/uart_tx_byte.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_byte.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
//
// Single-byte UART transmitter for the RS-232 test design. It accepts one byte
// per request from the sample-dump sender and shifts it out LSB first. Frames
// are 8N1 by default. With UART_TX_PARITY_EN defined they are 8E1, with the
// even-parity bit sent between data bit 7 and the stop bit. Only one byte is
// in flight at a time; requests made while busy are dropped, not queued.
//
// Parameters:
//   CLK_FREQ      system clock frequency in Hz
//   BAUD          line rate in bits/s
//   CLKS_PER_BIT  clock cycles per bit time (>= 2); overridable for simulation
//
// Ports:
//   iClk       in   system clock, rising edge
//   iRst_n     in   asynchronous active-low reset
//   iData      in   byte to send, sampled only on the accepting edge
//   iSend      in   send request, level-sampled, honoured only when idle
//   oUart_Txd  out  serial line (idle high), registered
//   oBusy      out  high from the accepting edge until the frame completes
//   oTx_done   out  one-cycle pulse once the stop bit has been sent
//
// Macro: UART_TX_PARITY_EN compiles in the even-parity bit (8E1 frames).
// -----------------------------------------------------------------------------
module uart_tx_byte #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic [7:0] iData,
  input  logic       iSend,
  output logic       oUart_Txd,
  output logic       oBusy,
  output logic       oTx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic             txd_q;
  logic             busy_q;
  logic             done_q;
`ifdef UART_TX_PARITY_EN
  logic             par_q;
`endif

  logic bit_end;
  logic accept;

  // Last cycle of the current bit time.
  assign bit_end = (cnt_q == CNT_LAST);
  assign accept  = (state_q == S_IDLE) && iSend;

  // Control FSM. The line value is registered one edge ahead, so each state
  // transition also loads the level the next state drives.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE) begin
        cnt_q <= bit_end ? '0 : cnt_q + CNT_W'(1);
      end
      case (state_q)
        S_IDLE: begin
          txd_q  <= 1'b1;
          busy_q <= 1'b0;
          if (iSend) begin
            state_q <= S_START;
            cnt_q   <= '0;
            idx_q   <= '0;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state_q <= S_DATA;
            txd_q   <= shift_q[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
              txd_q   <= par_q;
`else
              state_q <= S_STOP;
              txd_q   <= 1'b1;
`endif
            end else begin
              idx_q <= idx_q + 3'd1;
              // shift_q moves right on this same edge; bit 1 is the next bit.
              txd_q <= shift_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            state_q <= S_STOP;
            txd_q   <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            state_q <= S_IDLE;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          idx_q   <= '0;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Data path: byte latched on accept, shifted at each data-bit boundary.
  // No reset needed; it is always loaded before the FSM reads it.
  always_ff @(posedge iClk) begin
    if (accept) begin
      shift_q <= iData;
`ifdef UART_TX_PARITY_EN
      par_q   <= ^iData;
`endif
    end else if ((state_q == S_DATA) && bit_end) begin
      shift_q <= {1'b0, shift_q[7:1]};
    end
  end

  assign oUart_Txd = txd_q;
  assign oBusy     = busy_q;
  assign oTx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_byte.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_byte: directed bench for uart_tx_byte with CLKS_PER_BIT=4.
// Cycle c of a frame is the clock period that starts c edges after the
// accepting edge; outputs are sampled on the falling edge of that period.
// -----------------------------------------------------------------------------
module tb_uart_tx_byte;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int L = NB * C;

  logic       iClk;
  logic       iRst_n;
  logic [7:0] iData;
  logic       iSend;
  logic       oUart_Txd;
  logic       oBusy;
  logic       oTx_done;

  int checks   = 0;
  int failures = 0;

  uart_tx_byte #(
    .CLK_FREQ    (50000000),
    .BAUD        (115200),
    .CLKS_PER_BIT(C)
  ) dut (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .iData    (iData),
    .iSend    (iSend),
    .oUart_Txd(oUart_Txd),
    .oBusy    (oBusy),
    .oTx_done (oTx_done)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  task automatic chk(input string tag, input int c, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, c, obs, exp);
    end
  endtask

  // Line bits of a frame in transmit order, index 0 = start bit.
  function automatic logic [10:0] frame_bits(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  task automatic idle_check(input string tag, input int n);
    for (int c = 1; c <= n; c++) begin
      @(negedge iClk);
      chk({tag, "_txd"},  c, oUart_Txd, 1'b1);
      chk({tag, "_busy"}, c, oBusy,     1'b0);
      chk({tag, "_done"}, c, oTx_done,  1'b0);
    end
  endtask

  // Requests byte d on the next edge, then checks ncyc cycles of the frame.
  // In cycle 1 iSend becomes 'hold' and iData becomes d_after; in cycle
  // poke_c (if nonzero) a one-cycle request carrying poke_d is injected.
  task automatic send_frame(input string tag, input logic [7:0] d, input logic hold,
                            input logic [7:0] d_after, input int poke_c,
                            input logic [7:0] poke_d, input int ncyc);
    logic [10:0] fr;
    logic        exp_txd;
    fr    = frame_bits(d);
    iData = d;
    iSend = 1'b1;
    @(posedge iClk);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge iClk);
      if (c == 1) begin
        iSend = hold;
        iData = d_after;
      end
      if (poke_c != 0 && c == poke_c) begin
        iSend = 1'b1;
        iData = poke_d;
      end
      if (poke_c != 0 && c == poke_c + 1) iSend = hold;
      exp_txd = (c <= L) ? fr[(c - 1) / C] : 1'b1;
      chk({tag, "_txd"},  c, oUart_Txd, exp_txd);
      chk({tag, "_busy"}, c, oBusy,     (c <= L));
      chk({tag, "_done"}, c, oTx_done,  (c == L + 1));
    end
  endtask

  initial begin
    iRst_n = 1'b1;
    iSend  = 1'b0;
    iData  = 8'h00;

    // Reset state
    #2 iRst_n = 1'b0;
    #1;
    chk("rst_txd",  0, oUart_Txd, 1'b1);
    chk("rst_busy", 0, oBusy,     1'b0);
    chk("rst_done", 0, oTx_done,  1'b0);
    repeat (3) @(negedge iClk);
    chk("rst_hold_txd",  0, oUart_Txd, 1'b1);
    chk("rst_hold_busy", 0, oBusy,     1'b0);
    iRst_n = 1'b1;
    idle_check("idle", 20);

    // Single A5 frame: line 0,1,0,1,0,0,1,0,1,1 then done at cycle 1+NB*C
    send_frame("a5", 8'hA5, 1'b0, 8'hA5, 0, 8'h00, L + 1);
    idle_check("a5_after", 8);

    // iSend held high: 00 frame (iData changed to FF right after accept),
    // then an FF frame accepted on the edge that ends the done cycle
    send_frame("b2b_00", 8'h00, 1'b1, 8'hFF, 0, 8'h00, L + 1);
    send_frame("b2b_ff", 8'hFF, 1'b1, 8'hFF, 0, 8'h00, L + 1);
    iSend = 1'b0;
    idle_check("b2b_after", 6);

    // Request at cycle 10 with different data is ignored
    send_frame("ign", 8'h5A, 1'b0, 8'h5A, 10, 8'hC3, L + 1);
    idle_check("ign_after", 12);

    // Reset asserted at cycle 17 of a 3C frame
    send_frame("rst_pre", 8'h3C, 1'b0, 8'h3C, 0, 8'h00, 16);
    @(negedge iClk);
    chk("rst_c17_busy", 17, oBusy, 1'b1);
    iRst_n = 1'b0;
    #1;
    chk("rst_mid_txd",  17, oUart_Txd, 1'b1);
    chk("rst_mid_busy", 17, oBusy,     1'b0);
    chk("rst_mid_done", 17, oTx_done,  1'b0);
    repeat (2) @(negedge iClk);
    chk("rst_mid_hold_busy", 19, oBusy, 1'b0);
    iRst_n = 1'b1;
    idle_check("rst_idle", 10);
    send_frame("rst_post", 8'h3C, 1'b0, 8'h3C, 0, 8'h00, L + 1);
    idle_check("rst_post_after", 4);

`ifdef UART_TX_PARITY_EN
    // Parity 1 for 07 at cycles 37-40, stop 41-44, done 45; parity 0 for 03
    send_frame("par07", 8'h07, 1'b0, 8'h07, 0, 8'h00, L + 1);
    idle_check("par07_after", 3);
    send_frame("par03", 8'h03, 1'b0, 8'h03, 0, 8'h00, L + 1);
    idle_check("par03_after", 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
